cim_bank_wr_ctrl: RTL
=====================

// Module: cim_bank_wr_ctrl
// PURPOSE
//   Sequences weight loading into one cim_bank. Accepts a row-load command (start row, length),
//   then consumes a valid/ready stream of 24-bit words and drives D plus a one-hot WA strobe.
//   Keeps D stable for SETUP_CYC cycles before and HOLD_CYC cycles after each single-cycle strobe.
//   Sits between the macro-level weight DMA/host port and the bank write pins.
// PARAMETERS
//   ROWS      8   rows per bank; WA width; row index wraps modulo ROWS
//   HALF_W    12  bits per half-word; D = {a_half, b_half}, DATA_W = 2*HALF_W
//   SETUP_CYC 1   cycles D is stable with WA=0 before the strobe (>=1)
//   HOLD_CYC  1   cycles D is held with WA=0 after the strobe (>=1)
// PORTS
//   clk        in   1              clock
//   rst        in   1              synchronous reset, active-high
//   cmd_valid  in   1              load command valid
//   cmd_ready  out  1              high only in IDLE
//   cmd_row    in   $clog2(ROWS)   first row to write
//   cmd_len    in   $clog2(ROWS)+1 rows to write, 0..ROWS legal
//   wr_valid   in   1              data word valid
//   wr_ready   out  1              high only in LOAD
//   wr_data    in   2*HALF_W       {a_half, b_half}
//   D          out  2*HALF_W       registered bank data
//   WA         out  ROWS           registered one-hot write strobe, all-zero except in STROBE
//   busy       out  1              state != IDLE
//   done       out  1              one-cycle pulse at command completion
//   err        out  1              one-cycle pulse when a command is rejected
// BEHAVIOUR
//   Reset: state=IDLE; D=0, WA=0, done=0, err=0, busy=0; row/remaining counters=0.
//   IDLE: cmd_ready=1. On cmd_valid: cmd_len>ROWS -> err pulse next cycle, stay IDLE.
//     cmd_len==0 -> DONE. Else latch row=cmd_row, rem=cmd_len, go LOAD.
//   LOAD: wr_ready=1. On wr_valid, latch D<=wr_data, go SETUP. No handshake -> wait; D unchanged.
//   SETUP: SETUP_CYC cycles, WA=0. STROBE: one cycle, WA=1<<row.
//   HOLD: HOLD_CYC cycles, WA=0, D unchanged. Last HOLD cycle: rem--, row=(row+1)%ROWS;
//     go DONE if rem becomes 0, else go LOAD.
//   DONE: done=1 for exactly one cycle, then IDLE.
//   Per-word timing (1/1): handshake at cycle t, WA high at t+2, LOAD again at t+4; 4 cycles/word.
//   Wrap: cmd_row=6, cmd_len=4 writes rows 6,7,0,1.
//   WA is never multi-hot. WA is never high in the same cycle D changes.
//   Reset mid-operation (any state, incl. STROBE): next edge returns to reset values;
//     the command is abandoned and its partially written rows are left as written.
//   cmd_valid while busy: ignored (cmd_ready=0). wr_valid outside LOAD: ignored.
// CONFIGURATION
//   CIM_WR_READBACK_EN defined: adds inputs wb_a_in/wb_b_in [ROWS*HALF_W-1:0] from the bank, and a
//     sticky output rb_err. In the first HOLD cycle, compare {wb_a_in[row*HALF_W+:HALF_W],
//     wb_b_in[row*HALF_W+:HALF_W]} with D. A mismatch sets rb_err. rb_err clears on command
//     accept and on rst.
//   Undefined: those ports and that logic are absent. All other behaviour is identical.
// STRUCTURE
//   cim_pkg: ROWS/HALF_W defaults, state enum (IDLE,LOAD,SETUP,STROBE,HOLD,DONE),
//     row_onehot() function.
//   One shared phase counter serves SETUP and HOLD. No sub-module; the one-hot decode is the
//     package function.
// TESTING
//   1 Full load: row=0, len=8, words {12'h100+i,12'hA00+i} -> 8 strobes WA=01..80, done after
//     the 8th HOLD; bank reads wb_a=96'h107106...100, wb_b=96'hA07...A00.
//   2 Wrap: row=6, len=4 -> WA sequence 40,80,01,02 and a single done pulse.
//   3 len=0 -> done pulse 2 cycles after accept, WA stays 0. len=9 -> err pulse, no busy,
//     cmd_ready stays 1.
//   4 Backpressure: wr_valid low for 5 cycles between words -> no strobe while waiting;
//     D stable across every strobe.
//   5 rst in a STROBE cycle -> WA=0, D=0, busy=0 next cycle; a new command then completes
//     normally.
//   6 READBACK_EN: force the wb_a_in row 3 bit 0 flip during the write of 24'hDEADBE to row 3
//     -> rb_err=1, stays 1 until the next cmd accept.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared types and helpers for the cim_bank write controller.
// Row count, half-word width, FSM state encoding and the row one-hot decode.
package cim_pkg;

  localparam int unsigned CIM_ROWS     = 8;
  localparam int unsigned CIM_HALF_W   = 12;
  localparam int unsigned CIM_MAX_ROWS = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } cim_state_e;

  // Wide one-hot; callers truncate to their own row count.
  function automatic logic [CIM_MAX_ROWS-1:0] row_onehot(input int unsigned row);
    row_onehot = CIM_MAX_ROWS'(1) << row;
  endfunction

endpackage

// File: rtl/cim_bank_wr_ctrl.sv
// Weight-load sequencer for one cim_bank: command + word stream in, D and one-hot WA strobe out.
// Optional bank readback check is enabled with `define CIM_WR_READBACK_EN.
module cim_bank_wr_ctrl
  import cim_pkg::*;
#(
  parameter int unsigned ROWS      = CIM_ROWS,
  parameter int unsigned HALF_W    = CIM_HALF_W,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [$clog2(ROWS)-1:0]   cmd_row,
  input  logic [$clog2(ROWS):0]     cmd_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [2*HALF_W-1:0]       wr_data,
  output logic [2*HALF_W-1:0]       D,
  output logic [ROWS-1:0]           WA,
  output logic                      busy,
  output logic                      done,
  output logic                      err
`ifdef CIM_WR_READBACK_EN
  ,
  input  logic [ROWS*HALF_W-1:0]    wb_a_in,
  input  logic [ROWS*HALF_W-1:0]    wb_b_in,
  output logic                      rb_err
`endif
);

  localparam int unsigned DATA_W = 2 * HALF_W;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned LEN_W  = ROW_W + 1;
  localparam int unsigned PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  cim_state_e          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic [ROWS-1:0]     wa_q, wa_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;

  logic cmd_len_bad_c;
  logic cmd_acc_c;
  logic cmd_rej_c;
  logic wr_hs_c;
  logic setup_last_c;
  logic hold_last_c;

  assign cmd_len_bad_c = (cmd_len > LEN_W'(ROWS));
  assign cmd_acc_c     = (state_q == IDLE) && cmd_valid && !cmd_len_bad_c;
  assign cmd_rej_c     = (state_q == IDLE) && cmd_valid && cmd_len_bad_c;
  assign wr_hs_c       = (state_q == LOAD) && wr_valid;
  assign setup_last_c  = (state_q == SETUP) && (phase_q == PH_W'(SETUP_CYC - 1));
  assign hold_last_c   = (state_q == HOLD) && (phase_q == PH_W'(HOLD_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_acc_c) begin
          state_d = (cmd_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (wr_hs_c) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (setup_last_c) begin
          state_d = STROBE;
        end
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        if (hold_last_c) begin
          state_d = (rem_q == LEN_W'(1)) ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; WA/busy/ready are decoded from the next state so they align with it
  always_comb begin
    row_d       = row_q;
    rem_d       = rem_q;
    phase_d     = phase_q;
    d_d         = d_q;
    wa_d        = '0;
    done_d      = (state_q == DONE);
    err_d       = cmd_rej_c;
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == LOAD);

    if (cmd_acc_c) begin
      row_d = cmd_row;
      rem_d = cmd_len;
    end
    if (wr_hs_c) begin
      d_d     = wr_data;
      phase_d = '0;
    end
    if (state_q == SETUP) begin
      phase_d = setup_last_c ? '0 : phase_q + PH_W'(1);
    end
    if (state_q == HOLD) begin
      phase_d = phase_q + PH_W'(1);
      if (hold_last_c) begin
        phase_d = '0;
        rem_d   = rem_q - LEN_W'(1);
        row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end
    end
    if (state_d == STROBE) begin
      wa_d = ROWS'(row_onehot(32'(row_q)));
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      rem_q       <= '0;
      phase_q     <= '0;
      d_q         <= '0;
      wa_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      row_q       <= row_d;
      rem_q       <= rem_d;
      phase_q     <= phase_d;
      d_q         <= d_d;
      wa_q        <= wa_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  assign D         = d_q;
  assign WA        = wa_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;

`ifdef CIM_WR_READBACK_EN
  localparam int unsigned BANK_W = ROWS * HALF_W;
  localparam int unsigned BIDX_W = $clog2(BANK_W);

  logic [BIDX_W-1:0] rb_base_c;
  logic              rb_mismatch_c;
  logic              rb_err_q, rb_err_d;

  // Compare the bank's view of the just-strobed row against D in the first hold cycle
  assign rb_base_c     = BIDX_W'(32'(row_q) * HALF_W);
  assign rb_mismatch_c = (state_q == HOLD) && (phase_q == '0) &&
                         ({wb_a_in[rb_base_c +: HALF_W], wb_b_in[rb_base_c +: HALF_W]} != d_q);

  always_comb begin
    rb_err_d = rb_err_q;
    if (cmd_acc_c) begin
      rb_err_d = 1'b0;
    end else if (rb_mismatch_c) begin
      rb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_err_q <= 1'b0;
    end else begin
      rb_err_q <= rb_err_d;
    end
  end

  assign rb_err = rb_err_q;
`endif

endmodule
